// File: rtl/ysyx_23060203_mul_ctrl.sv
// Dispatch-side sequencer for the iterative Booth multiplier: decodes RV32M multiplies, issues one at a time, returns the selected half.
// Optional product reuse for repeated operands: define YSYX_23060203_MUL_REUSE_EN.
module ysyx_23060203_mul_ctrl (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic [4:0]  in_rd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_res,
   output logic [4:0]  out_rd,
   output logic        mul_in_valid,
   input  logic        mul_in_ready,
   output logic [1:0]  mul_in_sign,
   output logic [31:0] mul_in_a,
   output logic [31:0] mul_in_b,
   input  logic        mul_out_valid,
   output logic        mul_out_ready,
   input  logic [63:0] mul_out_prod,
   output logic        mul_flush
);

   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

   state_e      state_q, state_d;
   logic [1:0]  op_q, sign_q, in_sign;
   logic [4:0]  rd_q;
   logic [31:0] a_q, b_q, res_q, hit_res;
   logic        accept, capture, hit;

   always_comb begin
      in_sign = 2'b00;
      if (in_op == OP_MULH)        in_sign = 2'b11;
      else if (in_op == OP_MULHSU) in_sign = 2'b10;
   end

`ifdef YSYX_23060203_MUL_REUSE_EN
   logic        cv_q;
   logic [31:0] ca_q, cb_q;
   logic [1:0]  cs_q;
   logic [63:0] cp_q;

   // The low half of a product does not depend on operand signedness.
   assign hit     = cv_q && (in_a == ca_q) && (in_b == cb_q) &&
                    ((in_sign == cs_q) || (in_op == OP_MUL));
   assign hit_res = (in_op == OP_MUL) ? cp_q[31:0] : cp_q[63:32];

   always_ff @(posedge clock) begin
      if (reset) begin
         cv_q <= 1'b0;
         ca_q <= '0;
         cb_q <= '0;
         cs_q <= '0;
         cp_q <= '0;
      end else if (capture) begin
         cv_q <= 1'b1;
         ca_q <= a_q;
         cb_q <= b_q;
         cs_q <= sign_q;
         cp_q <= mul_out_prod;
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_res = 32'b0;
`endif

   always_comb begin
      state_d       = state_q;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      mul_in_valid  = 1'b0;
      mul_out_ready = 1'b0;
      case (state_q)
         IDLE: in_ready = 1'b1;
         REQ: begin
            mul_in_valid = 1'b1;
            if (mul_in_ready) state_d = WAIT;
         end
         WAIT: begin
            mul_out_ready = 1'b1;
            if (mul_out_valid) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Flush kills everything in flight, including a same-cycle request.
      if (flush) begin
         state_d       = IDLE;
         in_ready      = 1'b0;
         out_valid     = 1'b0;
         mul_in_valid  = 1'b0;
         mul_out_ready = 1'b0;
      end
      accept  = in_valid && in_ready;
      capture = (state_q == WAIT) && mul_out_valid && !flush;
      if (accept) state_d = hit ? DONE : REQ;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         sign_q  <= '0;
         rd_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q   <= in_op;
            sign_q <= in_sign;
            rd_q   <= in_rd;
            a_q    <= in_a;
            b_q    <= in_b;
            if (hit) res_q <= hit_res;
         end
         if (capture) res_q <= (op_q == OP_MUL) ? mul_out_prod[31:0] : mul_out_prod[63:32];
      end
   end

   assign out_res     = res_q;
   assign out_rd      = rd_q;
   assign mul_in_sign = sign_q;
   assign mul_in_a    = a_q;
   assign mul_in_b    = b_q;
   assign mul_flush   = flush;

endmodule

// File: tb/tb_ysyx_23060203_mul_ctrl.sv
// Randomized bench for ysyx_23060203_mul_ctrl with a 32-cycle multiplier stand-in and an arithmetic reference model.
module tb_ysyx_23060203_mul_ctrl;
   logic        clock = 1'b0, reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [1:0]  in_op, mul_in_sign;
   logic [31:0] in_a, in_b, out_res, mul_in_a, mul_in_b;
   logic [4:0]  in_rd, out_rd;
   logic        mul_in_valid, mul_in_ready, mul_out_valid, mul_out_ready, mul_flush;
   logic [63:0] mul_out_prod;

   int total = 0, bad = 0;

   always #5 clock = ~clock;

   ysyx_23060203_mul_ctrl dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_rd(out_rd),
      .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready), .mul_in_sign(mul_in_sign),
      .mul_in_a(mul_in_a), .mul_in_b(mul_in_b), .mul_out_valid(mul_out_valid),
      .mul_out_ready(mul_out_ready), .mul_out_prod(mul_out_prod), .mul_flush(mul_flush)
   );

   // Multiplier stand-in: accepts when idle, product valid 33 cycles after the handshake edge.
   logic m_busy;
   int   m_cnt, hs_cnt;
   assign mul_in_ready = !m_busy;
   always @(posedge clock) begin
      if (reset || mul_flush) begin
         m_busy <= 1'b0; m_cnt <= 0; mul_out_valid <= 1'b0; mul_out_prod <= '0;
         if (reset) hs_cnt <= 0;
      end else if (mul_in_valid && mul_in_ready) begin
         m_busy <= 1'b1; m_cnt <= 1; hs_cnt <= hs_cnt + 1;
         mul_out_prod <= (mul_in_sign[1] ? {{32{mul_in_a[31]}}, mul_in_a} : {32'b0, mul_in_a}) *
                         (mul_in_sign[0] ? {{32{mul_in_b[31]}}, mul_in_b} : {32'b0, mul_in_b});
      end else if (m_busy) begin
         if (mul_out_valid && mul_out_ready) begin
            m_busy <= 1'b0; mul_out_valid <= 1'b0;
         end else if (!mul_out_valid) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 32) mul_out_valid <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sb;
      logic [63:0] ua, ub, p;
      sa = $signed(a); sb = $signed(b); ua = {32'b0, a}; ub = {32'b0, b};
      case (op)
         2'b01:   p = sa * sb;
         2'b10:   p = sa * $signed(ub);
         default: p = ua * ub;
      endcase
      return (op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [1:0] ref_sign(input logic [1:0] op);
      return (op == 2'b01) ? 2'b11 : (op == 2'b10) ? 2'b10 : 2'b00;
   endfunction

   // Reference expectations and a one-entry operand cache.
   logic [31:0] e_res, e_a, e_b, ca, cb;
   logic [4:0]  e_rd;
   logic [1:0]  e_sign, cs;
   logic        e_hit, cv = 1'b0;
   int          hs0;

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rel);
      in_op = op; in_a = a; in_b = b; in_rd = rd; in_valid = 1'b1; out_ready = rel;
      #1;
      chk("accept_ready", 64'(in_ready), 64'(1));
      e_res = ref_res(op, a, b); e_rd = rd; e_sign = ref_sign(op); e_a = a; e_b = b;
`ifdef YSYX_23060203_MUL_REUSE_EN
      e_hit = cv && a == ca && b == cb && (e_sign == cs || op == 2'b00);
`else
      e_hit = 1'b0;
`endif
      hs0 = hs_cnt;
      @(posedge clock); #1;
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic collect(input int hold);
      int lat = 0;
      do begin
         @(negedge clock); lat++;
         if (mul_in_valid) chk("req_sign", 64'(mul_in_sign), 64'(e_sign));
      end while (!out_valid && lat < 100);
      chk("latency", 64'(lat), e_hit ? 64'(1) : 64'(35));
      chk("out_res", 64'(out_res), 64'(e_res));
      chk("out_rd", 64'(out_rd), 64'(e_rd));
      chk("mul_reqs", 64'(hs_cnt - hs0), e_hit ? 64'(0) : 64'(1));
      if (!e_hit) begin cv = 1'b1; ca = e_a; cb = e_b; cs = e_sign; end
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         chk("hold_valid", 64'(out_valid), 64'(1));
         chk("hold_res", 64'(out_res), 64'(e_res));
      end
   endtask

   task automatic release_out;
      out_ready = 1'b1;
      @(posedge clock); #1 out_ready = 1'b0;
      @(negedge clock);
      chk("released", 64'(out_valid), 64'(0));
   endtask

   initial begin
      logic [31:0] ra, rb, pa, pb;
      logic [1:0]  rop;
      logic        any_out;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
      repeat (3) @(posedge clock);
      @(negedge clock); reset = 1'b0; #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_mul_in_valid", 64'(mul_in_valid), 64'(0));
      chk("rst_mul_out_ready", 64'(mul_out_ready), 64'(0));
      chk("rst_mul_flush", 64'(mul_flush), 64'(0));
      chk("rst_out_res", 64'(out_res), 64'(0));
      chk("rst_out_rd", 64'(out_rd), 64'(0));

      // Directed corner products.
      issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1'b0); collect(0);
      chk("mulhu_ff", 64'(out_res), 64'hFFFFFFFE);
      release_out();
      issue(2'b10, 32'hFFFFFFFF, 32'd2, 5'd6, 1'b0); collect(0);
      chk("mulhsu_m1x2", 64'(out_res), 64'hFFFFFFFF);
      release_out();
      issue(2'b00, 32'hFFFFFFFF, 32'd2, 5'd7, 1'b0); collect(0);
      chk("mul_m1x2", 64'(out_res), 64'hFFFFFFFE);
      release_out();
      issue(2'b01, 32'h80000000, 32'h80000000, 5'd8, 1'b0); collect(0);
      chk("mulh_min", 64'(out_res), 64'h40000000);
      release_out();
      issue(2'b00, 32'h80000000, 32'h80000000, 5'd9, 1'b0); collect(0);
      chk("mul_min", 64'(out_res), 64'h0);
      release_out();

      // Long backpressure; a pending request waits until out_ready rises.
      issue(2'b11, 32'h12345678, 32'h9ABCDEF0, 5'd10, 1'b0); collect(20);
      in_op = 2'b00; in_a = 32'd3; in_b = 32'd7; in_rd = 5'd11; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("blocked_ready", 64'(in_ready), 64'(0));
         @(negedge clock);
      end
      issue(2'b00, 32'd3, 32'd7, 5'd11, 1'b1); collect(0);
      chk("mul_3x7", 64'(out_res), 64'd21);
      release_out();

      // Flush 10 cycles into WAIT, with a request in the flush cycle that must be dropped.
      issue(2'b01, 32'hDEADBEEF, 32'h1234, 5'd12, 1'b0);
      repeat (12) @(negedge clock);
      flush = 1'b1; in_valid = 1'b1; in_op = 2'b11; in_a = 32'h55; in_b = 32'h66; #1;
      chk("flush_mul_flush", 64'(mul_flush), 64'(1));
      chk("flush_in_ready", 64'(in_ready), 64'(0));
      @(posedge clock); #1 flush = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      chk("post_flush_ready", 64'(in_ready), 64'(1));
      any_out = 1'b0;
      repeat (40) begin @(negedge clock); any_out |= out_valid | mul_in_valid; end
      chk("killed_op_silent", 64'(any_out), 64'(0));
      issue(2'b00, 32'd3, 32'd7, 5'd13, 1'b0); collect(0);
      chk("post_flush_3x7", 64'(out_res), 64'd21);
      release_out();

      // Reset in WAIT clears outputs and the operand cache.
      issue(2'b00, 32'd5, 32'd6, 5'd1, 1'b0); collect(0); release_out();
      issue(2'b01, 32'h11, 32'h22, 5'd2, 1'b0);
      repeat (10) @(negedge clock);
      reset = 1'b1; @(posedge clock); #1 reset = 1'b0; cv = 1'b0;
      @(negedge clock);
      chk("midrst_ready", 64'(in_ready), 64'(1));
      chk("midrst_valid", 64'(out_valid), 64'(0));
      chk("midrst_res", 64'(out_res), 64'(0));
      issue(2'b00, 32'd5, 32'd6, 5'd3, 1'b0); collect(0);
      release_out();

      // Random ops, mixing chained accepts and repeated operands.
      pa = 32'd1; pb = 32'd1;
      for (int n = 0; n < 40; n++) begin
         rop = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0: begin ra = pa; rb = pb; end
            1: begin
               ra = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'hFFFFFFFF;
               rb = ($urandom_range(0, 1) != 0) ? 32'h7FFFFFFF : 32'h00000001;
            end
            default: begin ra = $urandom; rb = $urandom; end
         endcase
         pa = ra; pb = rb;
         if (n > 0 && $urandom_range(0, 1) != 0) begin
            issue(rop, ra, rb, 5'($urandom_range(0, 31)), 1'b1);
         end else begin
            if (n > 0) release_out();
            issue(rop, ra, rb, 5'($urandom_range(0, 31)), 1'b0);
         end
         collect($urandom_range(0, 3));
      end
      release_out();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ysyx_23060203_mul_ctrl.md
# ysyx_23060203_mul_ctrl

Sequencing controller between the EXU dispatch stage and the iterative 32-cycle Booth multiplier. It decodes RV32M multiply ops (MUL/MULH/MULHSU/MULHU) into multiplier sign controls, issues one request at a time, and captures the 64-bit product. It returns the selected 32-bit half tagged with the destination register, and propagates pipeline flush. An optional product-reuse register lets a MULH/MUL pair on identical operands skip the second multiply.

## Interface
Parameters: none.
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; kills the in-flight op
- in_valid  in  1  dispatch request
- in_ready  out  1  controller accepts request this cycle
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_a, in_b  in  32  rs1, rs2 values
- in_rd  in  5  destination tag
- out_valid  out  1  result available
- out_ready  in  1  writeback accepts result
- out_res  out  32  selected product half
- out_rd  out  5  tag of result
- mul_in_valid  out  1  request to multiplier
- mul_in_ready  in  1  multiplier accepts
- mul_in_sign  out  2  [1] treat a as signed, [0] treat b as signed
- mul_in_a, mul_in_b  out  32  operands to multiplier
- mul_out_valid  in  1  product valid
- mul_out_ready  out  1  controller consumes product
- mul_out_prod  in  64  product
- mul_flush  out  1  flush to multiplier, equal to flush

## Operation
- Sign decode: MUL→00, MULH→11, MULHSU→10, MULHU→00.
- Result select: MUL→prod[31:0], all others→prod[63:32].
- FSM states:
  - IDLE: in_ready=1. On in_valid & ~flush, latch op/rd/a/b/sign. Go to DONE on reuse hit, otherwise to REQ.
  - REQ: mul_in_valid=1 with the latched operands. On mul_in_ready, go to WAIT.
  - WAIT: mul_out_ready=1. On mul_out_valid, register the product, load the reuse register, go to DONE.
  - DONE: out_valid=1; out_res/out_rd come from registers. On out_ready, go to IDLE, or accept a new request in the same cycle (in_ready = IDLE | (DONE & out_ready)).
- in_ready is forced 0 whenever flush=1.
- Flush in any state:
  - Next state is IDLE and the latched op is dropped.
  - out_valid is forced 0 in the flush cycle.
  - mul_flush=1 in the same cycle.
  - in_valid in the flush cycle is ignored.
- Exactly one op is outstanding at the multiplier at any time.

## Timing
- Reset:
  - State is IDLE.
  - in_ready=1; out_valid, mul_in_valid, mul_out_ready and mul_flush are 0.
  - out_res=0, out_rd=0, reuse register invalid.
- Accept at cycle 0:
  - Cycle 1: REQ handshake; the multiplier is idle, so mul_in_ready=1.
  - Cycle 34: mul_out_valid.
  - Cycle 35: out_valid=1.
  - Miss latency is 35 cycles.
- Reuse hit: out_valid at cycle 1.
- Back-to-back: an op accepted in DONE sees the same latencies counted from its accept cycle.
- out_valid holds, with out_res/out_rd stable, until out_ready or flush.
- A flush in the same cycle as mul_out_valid discards the product and leaves the reuse register unchanged.
- Reset mid-operation: the controller returns to IDLE next cycle. The multiplier resets on the same reset.

## Configuration
- YSYX_23060203_MUL_REUSE_EN defined:
  - Keep a register {valid, a, b, sign, prod[63:0]} loaded on every captured product.
  - Hit when valid & a==cached a & b==cached b, and either sign==cached sign or op is MUL (low half is sign-independent).
  - A hit bypasses REQ/WAIT and goes IDLE→DONE.
  - The register is cleared only by reset.
- Undefined: no reuse register, every op takes the miss path, and the hit logic is absent.

## Test plan
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF, rd=5 → out_valid 35 cycles after accept, out_res=0xFFFFFFFE, out_rd=5, mul_in_sign=00.
- MULHSU a=0xFFFFFFFF (−1), b=2 → mul_in_sign=10, out_res=0xFFFFFFFF. MUL with the same operands → out_res=0xFFFFFFFE.
- MULH a=0x80000000, b=0x80000000 → out_res=0x40000000. With REUSE_EN, an immediately following MUL on the same operands → out_valid 1 cycle after accept, out_res=0x00000000, no mul_in_valid. Without REUSE_EN → 35-cycle latency.
- Flush asserted 10 cycles into WAIT → mul_flush=1 that cycle, in_ready=0 that cycle. Next cycle: IDLE, in_ready=1, no out_valid from the killed op. The next op (MUL 3×7) returns 21.
- out_ready held low 20 cycles in DONE → out_valid and out_res stable throughout. A new in_valid is accepted only in the cycle out_ready rises.
- Reset asserted in WAIT → next cycle in_ready=1, out_valid=0, out_res=0. With REUSE_EN, a subsequent repeat of the previous operands misses.
